hazard_stall_ctrl: RTL and testbench

//  Parametrised pipeline hazard/stall controller for the 5-stage MIPS core; sits beside the ID stage.

---
 rtl/hazard_stall_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage MIPS core, sitting beside ID.
// Detects load-use and branch-in-ID operand hazards, holds the whole pipeline
// while data memory is busy, and counts bubble cycles in a saturating counter.
// Control outputs are combinational so a hazard stalls in the cycle it is seen;
// the FSM only stretches stalls that last longer than one cycle.
module hazard_stall_ctrl #(
  parameter int REG_AW       = 5,
  parameter int LOAD_LAT     = 1,
  parameter int BRANCH_IN_ID = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_ex_memread_i,
  input  logic              id_ex_regwrite_i,
  input  logic [REG_AW-1:0] id_ex_rd_i,
  input  logic              ex_mem_memread_i,
  input  logic [REG_AW-1:0] ex_mem_rd_i,
  input  logic [REG_AW-1:0] if_id_rs_i,
  input  logic [REG_AW-1:0] if_id_rt_i,
  input  logic              if_id_rs_used_i,
  input  logic              if_id_rt_used_i,
  input  logic              if_id_branch_i,
  input  logic              branch_taken_i,
  input  logic              mem_busy_i,
  input  logic              cnt_clr_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              bubble_o,
  output logic              flush_o,
  output logic              freeze_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STALL  = 2'd1,
    S_FREEZE = 2'd2
  } state_t;

  localparam bit         BR_ID  = (BRANCH_IN_ID != 0);
  localparam logic [3:0] LAT_N  = 4'(LOAD_LAT);

  state_t             state_q, state_d;
  state_t             ret_q, ret_d;
  logic [2:0]         rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q;

  state_t             eff_state;
  logic               br_chk;
  logic               hit_lu, hit_ba, hit_bl, any_hit;
  logic [3:0]         n_lu, n_max;
  logic               stall;

  // A source register hazards only if the ID instruction really reads it; $0 never does.
  function automatic logic reg_match(input logic [REG_AW-1:0] r,
                                     input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rt,
                                     input logic              rs_used,
                                     input logic              rt_used);
    return (r != '0) && ((rs_used && (r == rs)) || (rt_used && (r == rt)));
  endfunction

  // Hazard detection and bubble-count selection (largest requirement wins).
  always_comb begin
    br_chk  = BR_ID && if_id_branch_i;
    hit_lu  = id_ex_memread_i &&
              reg_match(id_ex_rd_i, if_id_rs_i, if_id_rt_i, if_id_rs_used_i, if_id_rt_used_i);
    hit_ba  = br_chk && id_ex_regwrite_i && !id_ex_memread_i &&
              reg_match(id_ex_rd_i, if_id_rs_i, if_id_rt_i, if_id_rs_used_i, if_id_rt_used_i);
    hit_bl  = br_chk && ex_mem_memread_i &&
              reg_match(ex_mem_rd_i, if_id_rs_i, if_id_rt_i, if_id_rs_used_i, if_id_rt_used_i);
    any_hit = hit_lu || hit_ba || hit_bl;
    n_lu    = LAT_N + {3'b000, br_chk};
    n_max   = '0;
    if (hit_ba || hit_bl) n_max = 4'd1;
    if (hit_lu && (n_lu > n_max)) n_max = n_lu;
  end

  // Next-state logic. A FREEZE cycle with memory ready behaves exactly like the
  // stored state, so the interrupted stall resumes without losing a cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    ret_d     = ret_q;
    rem_d     = rem_q;
    eff_state = (state_q == S_FREEZE) ? ret_q : state_q;
    stall     = (eff_state == S_STALL) || ((eff_state == S_IDLE) && any_hit);

    if (mem_busy_i) begin
      state_d = S_FREEZE;
      ret_d   = eff_state;
    end else begin
      case (eff_state)
        S_STALL: begin
          rem_d   = rem_q - 3'd1;
          state_d = (rem_q == 3'd1) ? S_IDLE : S_STALL;
        end
        default: begin
          state_d = S_IDLE;
          if (any_hit && (n_max > 4'd1)) begin
            rem_d   = 3'(n_max - 4'd1);
            state_d = S_STALL;
          end
        end
      endcase
    end
  end

  // Pipeline control outputs: reset forces normal flow, freeze beats stall.
  always_comb begin
    pc_write_o    = 1'b1;
    if_id_write_o = 1'b1;
    bubble_o      = 1'b0;
    flush_o       = 1'b0;
    freeze_o      = 1'b0;
    if (!rst_i) begin
      if (mem_busy_i) begin
        freeze_o      = 1'b1;
        pc_write_o    = 1'b0;
        if_id_write_o = 1'b0;
      end else if (stall) begin
        pc_write_o    = 1'b0;
        if_id_write_o = 1'b0;
        bubble_o      = 1'b1;
      end else begin
        flush_o       = branch_taken_i;
      end
    end
  end

  // State, remaining-bubble and saturating counter registers.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      rem_q   <= rem_d;
      if (cnt_clr_i)                       cnt_q <= '0;
      else if (bubble_o && (cnt_q != '1))  cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: three instances (LOAD_LAT=1, LOAD_LAT=3, CNT_W=2)
// share one stimulus bundle; each directed cycle pushes its hand-computed
// expectation for one instance, and a negedge monitor pops and compares.
module tb_hazard_stall_ctrl;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       rst_i;
  logic       id_ex_memread_i, id_ex_regwrite_i, ex_mem_memread_i;
  logic [4:0] id_ex_rd_i, ex_mem_rd_i, if_id_rs_i, if_id_rt_i;
  logic       if_id_rs_used_i, if_id_rt_used_i, if_id_branch_i, branch_taken_i;
  logic       mem_busy_i, cnt_clr_i;

  logic        pcw [3];
  logic        ifw [3];
  logic        bub [3];
  logic        fl  [3];
  logic        frz [3];
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  hazard_stall_ctrl #(.LOAD_LAT(1)) u_lat1 (
    .clk_i, .rst_i, .id_ex_memread_i, .id_ex_regwrite_i, .id_ex_rd_i,
    .ex_mem_memread_i, .ex_mem_rd_i, .if_id_rs_i, .if_id_rt_i,
    .if_id_rs_used_i, .if_id_rt_used_i, .if_id_branch_i, .branch_taken_i,
    .mem_busy_i, .cnt_clr_i,
    .pc_write_o(pcw[0]), .if_id_write_o(ifw[0]), .bubble_o(bub[0]),
    .flush_o(fl[0]), .freeze_o(frz[0]), .stall_cnt_o(cnt_a));

  hazard_stall_ctrl #(.LOAD_LAT(3)) u_lat3 (
    .clk_i, .rst_i, .id_ex_memread_i, .id_ex_regwrite_i, .id_ex_rd_i,
    .ex_mem_memread_i, .ex_mem_rd_i, .if_id_rs_i, .if_id_rt_i,
    .if_id_rs_used_i, .if_id_rt_used_i, .if_id_branch_i, .branch_taken_i,
    .mem_busy_i, .cnt_clr_i,
    .pc_write_o(pcw[1]), .if_id_write_o(ifw[1]), .bubble_o(bub[1]),
    .flush_o(fl[1]), .freeze_o(frz[1]), .stall_cnt_o(cnt_b));

  hazard_stall_ctrl #(.LOAD_LAT(1), .CNT_W(2)) u_cnt2 (
    .clk_i, .rst_i, .id_ex_memread_i, .id_ex_regwrite_i, .id_ex_rd_i,
    .ex_mem_memread_i, .ex_mem_rd_i, .if_id_rs_i, .if_id_rt_i,
    .if_id_rs_used_i, .if_id_rt_used_i, .if_id_branch_i, .branch_taken_i,
    .mem_busy_i, .cnt_clr_i,
    .pc_write_o(pcw[2]), .if_id_write_o(ifw[2]), .bubble_o(bub[2]),
    .flush_o(fl[2]), .freeze_o(frz[2]), .stall_cnt_o(cnt_c));

  typedef struct {
    int          dut;
    logic [4:0]  flags;   // {pc_write, if_id_write, bubble, flush, freeze}
    logic [15:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      exp_t        e;
      string       nm;
      logic [15:0] act_cnt;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      act_cnt = (e.dut == 0) ? cnt_a : (e.dut == 1) ? cnt_b : {14'b0, cnt_c};
      check({nm, "_ctl"}, {11'b0, pcw[e.dut], ifw[e.dut], bub[e.dut], fl[e.dut], frz[e.dut]},
            {11'b0, e.flags});
      check({nm, "_cnt"}, act_cnt, e.cnt);
    end
  end

  // Push one cycle's expectation, then advance to just after the next edge.
  task automatic cyc(input int d, input logic p, input logic b, input logic f,
                     input logic z, input int c, input string nm);
    exp_t e;
    e.dut   = d;
    e.flags = {p, p, b, f, z};
    e.cnt   = 16'(c);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_in();
    id_ex_memread_i  = 0; id_ex_regwrite_i = 0; id_ex_rd_i = 0;
    ex_mem_memread_i = 0; ex_mem_rd_i = 0;
    if_id_rs_i = 0; if_id_rt_i = 0; if_id_rs_used_i = 0; if_id_rt_used_i = 0;
    if_id_branch_i = 0; branch_taken_i = 0; mem_busy_i = 0; cnt_clr_i = 0;
  endtask

  // lw rd in EX, ID instruction reads rd as rs and $4 as rt.
  task automatic lw_hazard(input logic [4:0] rd);
    id_ex_memread_i = 1; id_ex_rd_i = rd;
    if_id_rs_i = rd; if_id_rs_used_i = 1;
    if_id_rt_i = 5'd4; if_id_rt_used_i = 1;
  endtask

  // One reset edge, then a checked cycle with rst_i still high and whatever
  // hazard inputs the caller left applied: outputs must be forced to normal.
  task automatic do_reset(input int d, input string nm);
    rst_i = 1;
    @(posedge clk_i);
    #1;
    cyc(d, 1, 0, 0, 0, 0, nm);
    rst_i = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1;
    clr_in();

    // ---------------- LOAD_LAT=1 ----------------
    lw_hazard(5'd2);
    do_reset(0, "a_rst_force");
    cyc(0, 0, 1, 0, 0, 0, "a_lu_stall");
    clr_in();
    cyc(0, 1, 0, 0, 0, 1, "a_lu_after");
    id_ex_memread_i = 1; id_ex_rd_i = 0;
    if_id_rs_i = 0; if_id_rs_used_i = 1; if_id_rt_i = 0; if_id_rt_used_i = 1;
    cyc(0, 1, 0, 0, 0, 1, "a_zero_reg");
    clr_in();
    id_ex_memread_i = 1; id_ex_rd_i = 5'd2;
    if_id_rs_i = 5'd5; if_id_rs_used_i = 1; if_id_rt_i = 5'd2; if_id_rt_used_i = 0;
    cyc(0, 1, 0, 0, 0, 1, "a_rt_unused");
    clr_in();
    if_id_branch_i = 1; branch_taken_i = 1; if_id_rs_i = 5'd7; if_id_rs_used_i = 1;
    cyc(0, 1, 0, 1, 0, 1, "a_br_taken");
    clr_in();
    if_id_branch_i = 1; id_ex_regwrite_i = 1; id_ex_rd_i = 5'd2;
    if_id_rs_i = 5'd2; if_id_rs_used_i = 1;
    cyc(0, 0, 1, 0, 0, 1, "a_ba_stall");
    clr_in();
    cyc(0, 1, 0, 0, 0, 2, "a_ba_after");
    id_ex_regwrite_i = 1; id_ex_rd_i = 5'd2; if_id_rs_i = 5'd2; if_id_rs_used_i = 1;
    cyc(0, 1, 0, 0, 0, 2, "a_alu_nobr");
    clr_in();
    if_id_branch_i = 1; branch_taken_i = 1; ex_mem_memread_i = 1; ex_mem_rd_i = 5'd3;
    if_id_rt_i = 5'd3; if_id_rt_used_i = 1;
    cyc(0, 0, 1, 0, 0, 2, "a_bl_stall");
    ex_mem_memread_i = 0;
    cyc(0, 1, 0, 1, 0, 3, "a_bl_resolve");
    clr_in();
    // Freeze while a hazard is pending in IDLE: freeze wins, hazard seen afterwards.
    lw_hazard(5'd6); mem_busy_i = 1;
    cyc(0, 0, 0, 0, 1, 3, "a_frz_idle");
    mem_busy_i = 0;
    cyc(0, 0, 1, 0, 0, 3, "a_frz_release");
    clr_in();
    cyc(0, 1, 0, 0, 0, 4, "a_frz_done");

    // ---------------- LOAD_LAT=3, dependent branch: 4 bubbles ----------------
    lw_hazard(5'd2); if_id_branch_i = 1; branch_taken_i = 1;
    do_reset(1, "b_rst_force");
    cyc(1, 0, 1, 0, 0, 0, "b_lubr_c0");
    id_ex_memread_i = 0;
    cyc(1, 0, 1, 0, 0, 1, "b_lubr_c1");
    cyc(1, 0, 1, 0, 0, 2, "b_lubr_c2");
    cyc(1, 0, 1, 0, 0, 3, "b_lubr_c3");
    cyc(1, 1, 0, 1, 0, 4, "b_lubr_done");
    clr_in();

    // LOAD_LAT=3 stall frozen after two bubbles for 5 cycles, then one more bubble.
    lw_hazard(5'd2);
    do_reset(1, "b_rst_frz");
    cyc(1, 0, 1, 0, 0, 0, "b_frz_c0");
    clr_in();
    cyc(1, 0, 1, 0, 0, 1, "b_frz_c1");
    mem_busy_i = 1;
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1, 2, "b_frz_hold");
    mem_busy_i = 0;
    cyc(1, 0, 1, 0, 0, 2, "b_frz_last");
    cyc(1, 1, 0, 0, 0, 3, "b_frz_done");

    // Reset in the middle of a stall aborts it.
    lw_hazard(5'd2); if_id_branch_i = 1;
    do_reset(1, "b_rst_stall");
    cyc(1, 0, 1, 0, 0, 0, "b_rs_c0");
    clr_in();
    cyc(1, 0, 1, 0, 0, 1, "b_rs_c1");
    rst_i = 1;
    cyc(1, 1, 0, 0, 0, 2, "b_rs_mid");
    rst_i = 0;
    cyc(1, 1, 0, 0, 0, 0, "b_rs_after");

    // ---------------- CNT_W=2 saturation and clear ----------------
    do_reset(2, "c_rst_force");
    lw_hazard(5'd2);
    cyc(2, 0, 1, 0, 0, 0, "c_sat0");
    cyc(2, 0, 1, 0, 0, 1, "c_sat1");
    cyc(2, 0, 1, 0, 0, 2, "c_sat2");
    cyc(2, 0, 1, 0, 0, 3, "c_sat3");
    cyc(2, 0, 1, 0, 0, 3, "c_sat4");
    clr_in();
    cyc(2, 1, 0, 0, 0, 3, "c_sat_hold");
    lw_hazard(5'd2); cnt_clr_i = 1;
    cyc(2, 0, 1, 0, 0, 3, "c_clr_bub");
    clr_in();
    cyc(2, 1, 0, 0, 0, 0, "c_clr_done");

    @(negedge clk_i);
    @(posedge clk_i);
    check("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
